// File: rtl/memory_arbiter.sv
// Round-robin arbiter giving two four-phase requesters shared access to one
// memory port, with a per-access timeout and registered outputs throughout.
module memory_arbiter #(
  parameter int unsigned timeout_cycles = 255
) (
  input  logic        clock,
  input  logic        reset,

  input  logic [31:0] requester0_address,
  input  logic [31:0] requester0_data_out,
  input  logic [1:0]  requester0_data_size,
  input  logic        requester0_operation,
  input  logic        requester0_enable,
  output logic [31:0] requester0_data_in,
  output logic        requester0_ready,
  output logic        requester0_error,

  input  logic [31:0] requester1_address,
  input  logic [31:0] requester1_data_out,
  input  logic [1:0]  requester1_data_size,
  input  logic        requester1_operation,
  input  logic        requester1_enable,
  output logic [31:0] requester1_data_in,
  output logic        requester1_ready,
  output logic        requester1_error,

  output logic [31:0] memory_address,
  output logic [31:0] memory_data_out,
  output logic [1:0]  memory_data_size,
  output logic        memory_operation,
  output logic        memory_enable,
  input  logic [31:0] memory_data_in,
  input  logic        memory_ready,

  output logic        grant,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(timeout_cycles - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        op_q, op_d;
  logic        mem_en_q, mem_en_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] data0_q, data0_d, data1_q, data1_d;
  logic        rdy0_q, rdy0_d, rdy1_q, rdy1_d;
  logic        err0_q, err0_d, err1_q, err1_d;

  logic        sel;
  logic        resp_set;
  logic        resp_err;
  logic [31:0] resp_data;
  logic        resp_clr;
  logic        owner_en;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    op_d         = op_q;
    mem_en_d     = mem_en_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    data0_d      = data0_q;
    data1_d      = data1_q;
    rdy0_d       = rdy0_q;
    rdy1_d       = rdy1_q;
    err0_d       = err0_q;
    err1_d       = err1_q;
    sel          = 1'b0;
    resp_set     = 1'b0;
    resp_err     = 1'b0;
    resp_data    = '0;
    resp_clr     = 1'b0;
    owner_en     = grant_q ? requester1_enable : requester0_enable;

    unique case (state_q)
      IDLE: begin
        if (requester0_enable || requester1_enable) begin
          sel          = (requester0_enable && requester1_enable) ? ~last_grant_q
                                                                  : requester1_enable;
          grant_d      = sel;
          last_grant_d = sel;
          addr_d       = sel ? requester1_address    : requester0_address;
          wdata_d      = sel ? requester1_data_out   : requester0_data_out;
          size_d       = sel ? requester1_data_size  : requester0_data_size;
          op_d         = sel ? requester1_operation  : requester0_operation;
          cnt_d        = '0;
          if (size_d == 2'd3) begin
            // Illegal size is answered locally; the memory never sees it.
            resp_set = 1'b1;
            resp_err = 1'b1;
            state_d  = RESPOND;
          end else begin
            mem_en_d = 1'b1;
            state_d  = REQUEST;
          end
        end
      end

      REQUEST: begin
        if (memory_ready) begin
          resp_set  = 1'b1;
          resp_data = op_q ? '0 : memory_data_in;
          mem_en_d  = 1'b0;
          state_d   = RESPOND;
        end else if (cnt_q == TMO_LAST) begin
          resp_set = 1'b1;
          resp_err = 1'b1;
          mem_en_d = 1'b0;
          state_d  = RESPOND;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      RESPOND: begin
        if (!owner_en && !memory_ready) begin
          resp_clr = 1'b1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (resp_set) begin
      if (grant_d) begin
        rdy1_d  = 1'b1;
        err1_d  = resp_err;
        data1_d = resp_data;
      end else begin
        rdy0_d  = 1'b1;
        err0_d  = resp_err;
        data0_d = resp_data;
      end
    end

    if (resp_clr) begin
      rdy0_d  = 1'b0;
      err0_d  = 1'b0;
      data0_d = '0;
      rdy1_d  = 1'b0;
      err1_d  = 1'b0;
      data1_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      op_q         <= 1'b0;
      mem_en_q     <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      data0_q      <= '0;
      data1_q      <= '0;
      rdy0_q       <= 1'b0;
      rdy1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      op_q         <= op_d;
      mem_en_q     <= mem_en_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
      rdy0_q       <= rdy0_d;
      rdy1_q       <= rdy1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
    end
  end

  assign memory_address     = addr_q;
  assign memory_data_out    = wdata_q;
  assign memory_data_size   = size_q;
  assign memory_operation   = op_q;
  assign memory_enable      = mem_en_q;
  assign grant              = grant_q;
  assign busy               = (state_q != IDLE);
  assign requester0_data_in = data0_q;
  assign requester0_ready   = rdy0_q;
  assign requester0_error   = err0_q;
  assign requester1_data_in = data1_q;
  assign requester1_ready   = rdy1_q;
  assign requester1_error   = err1_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: arbitration order, data forwarding,
// timeout, illegal size and mid-transaction reset.
module tb_memory_arbiter;

  logic        clock;
  logic        reset;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic [1:0]  r0_size;
  logic        r0_op, r0_en, r0_rdy, r0_err;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic [1:0]  r1_size;
  logic        r1_op, r1_en, r1_rdy, r1_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [1:0]  m_size;
  logic        m_op, m_en, m_rdy;
  logic        grant, busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  memory_arbiter #(.timeout_cycles(4)) dut (
    .clock                (clock),
    .reset                (reset),
    .requester0_address   (r0_addr),
    .requester0_data_out  (r0_wdata),
    .requester0_data_size (r0_size),
    .requester0_operation (r0_op),
    .requester0_enable    (r0_en),
    .requester0_data_in   (r0_rdata),
    .requester0_ready     (r0_rdy),
    .requester0_error     (r0_err),
    .requester1_address   (r1_addr),
    .requester1_data_out  (r1_wdata),
    .requester1_data_size (r1_size),
    .requester1_operation (r1_op),
    .requester1_enable    (r1_en),
    .requester1_data_in   (r1_rdata),
    .requester1_ready     (r1_rdy),
    .requester1_error     (r1_err),
    .memory_address       (m_addr),
    .memory_data_out      (m_wdata),
    .memory_data_size     (m_size),
    .memory_operation     (m_op),
    .memory_enable        (m_en),
    .memory_data_in       (m_rdata),
    .memory_ready         (m_rdy),
    .grant                (grant),
    .busy                 (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Memory answers at the next edge, then the owner drops its request.
  task automatic serve(input logic who, input logic [31:0] mdata, input logic [31:0] exp);
    m_rdy   = 1'b1;
    m_rdata = mdata;
    tick();
    check("resp_mem_en", 32'(m_en), 32'd0);
    check("resp_rdy",    32'(who ? r1_rdy : r0_rdy), 32'd1);
    check("resp_data",   who ? r1_rdata : r0_rdata, exp);
    check("resp_err",    32'(who ? r1_err : r0_err), 32'd0);
    check("other_rdy",   32'(who ? r0_rdy : r1_rdy), 32'd0);
    check("other_data",  who ? r0_rdata : r1_rdata, 32'd0);
    m_rdy = 1'b0;
    if (who) r1_en = 1'b0;
    else     r0_en = 1'b0;
    tick();
    check("exit_busy",   32'(busy), 32'd0);
    check("exit_rdy",    32'(who ? r1_rdy : r0_rdy), 32'd0);
    check("exit_data",   who ? r1_rdata : r0_rdata, 32'd0);
  endtask

  initial begin
    int unsigned en_cycles;
    reset = 1'b0;
    r0_addr = '0; r0_wdata = '0; r0_size = 2'd2; r0_op = 1'b0; r0_en = 1'b0;
    r1_addr = '0; r1_wdata = '0; r1_size = 2'd2; r1_op = 1'b0; r1_en = 1'b0;
    m_rdata = '0; m_rdy = 1'b0;

    tick(); tick();
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_mem_en", 32'(m_en), 32'd0);
    check("rst_m_addr", m_addr,    32'd0);
    check("rst_r0_rdy", 32'(r0_rdy), 32'd0);
    check("rst_r1_rdy", 32'(r1_rdy), 32'd0);
    reset = 1'b1;
    tick();

    // Tie after reset: 0, then 1, then 0, then 1.
    r0_addr = 32'h100; r1_addr = 32'h200;
    r0_en = 1'b1; r1_en = 1'b1;
    tick();
    check("tie1_grant", 32'(grant), 32'd0);
    check("tie1_addr",  m_addr, 32'h100);
    check("tie1_mem_en", 32'(m_en), 32'd1);
    check("tie1_busy",  32'(busy), 32'd1);
    serve(1'b0, 32'h1111_1111, 32'h1111_1111);
    tick();
    check("tie1b_grant", 32'(grant), 32'd1);
    check("tie1b_addr",  m_addr, 32'h200);
    serve(1'b1, 32'h2222_2222, 32'h2222_2222);
    r0_en = 1'b1; r1_en = 1'b1;
    tick();
    check("tie2_grant", 32'(grant), 32'd0);
    serve(1'b0, 32'h3333_3333, 32'h3333_3333);
    tick();
    check("tie2b_grant", 32'(grant), 32'd1);
    serve(1'b1, 32'h4444_4444, 32'h4444_4444);

    // Single word read, memory answers at the first edge.
    r0_addr = 32'h100; r0_size = 2'd2; r0_op = 1'b0; r0_en = 1'b1;
    tick();
    check("rd_mem_en", 32'(m_en), 32'd1);
    check("rd_addr",   m_addr, 32'h100);
    check("rd_size",   32'(m_size), 32'd2);
    check("rd_op",     32'(m_op), 32'd0);
    serve(1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Byte write from requester 1; read data on the bus must not leak back.
    r1_addr = 32'h20; r1_wdata = 32'h0000_00A5; r1_size = 2'd0; r1_op = 1'b1; r1_en = 1'b1;
    tick();
    check("wr_grant", 32'(grant), 32'd1);
    check("wr_addr",  m_addr, 32'h20);
    check("wr_data",  m_wdata, 32'h0000_00A5);
    check("wr_size",  32'(m_size), 32'd0);
    check("wr_op",    32'(m_op), 32'd1);
    check("wr_r0_rdy", 32'(r0_rdy), 32'd0);
    serve(1'b1, 32'hFFFF_FFFF, 32'd0);

    // Timeout with timeout_cycles = 4.
    r0_addr = 32'h300; r0_size = 2'd2; r0_op = 1'b0; r0_en = 1'b1;
    m_rdata = 32'hCAFE_F00D;
    tick();
    en_cycles = 0;
    for (int i = 0; i < 12 && m_en; i++) begin
      en_cycles++;
      tick();
    end
    check("tmo_en_cycles", 32'(en_cycles), 32'd4);
    check("tmo_rdy",  32'(r0_rdy), 32'd1);
    check("tmo_err",  32'(r0_err), 32'd1);
    check("tmo_data", r0_rdata, 32'd0);
    tick();
    check("tmo_hold_rdy", 32'(r0_rdy), 32'd1);
    check("tmo_hold_busy", 32'(busy), 32'd1);
    r0_en = 1'b0;
    tick();
    check("tmo_exit_busy", 32'(busy), 32'd0);
    check("tmo_exit_err",  32'(r0_err), 32'd0);

    // Illegal size: answered locally with no memory cycle.
    r1_addr = 32'h40; r1_size = 2'd3; r1_op = 1'b0; r1_en = 1'b1;
    tick();
    check("ill_mem_en", 32'(m_en), 32'd0);
    check("ill_rdy",    32'(r1_rdy), 32'd1);
    check("ill_err",    32'(r1_err), 32'd1);
    check("ill_data",   r1_rdata, 32'd0);
    check("ill_r0_rdy", 32'(r0_rdy), 32'd0);
    r1_en = 1'b0;
    tick();
    check("ill_exit_busy", 32'(busy), 32'd0);

    // Reset during REQUEST after requester 0 was last granted.
    r1_size = 2'd2;
    r0_addr = 32'h500; r0_en = 1'b1;
    tick();
    check("mr_mem_en", 32'(m_en), 32'd1);
    reset = 1'b0;
    tick();
    check("mr_mem_en0", 32'(m_en), 32'd0);
    check("mr_busy",    32'(busy), 32'd0);
    check("mr_grant",   32'(grant), 32'd0);
    check("mr_m_addr",  m_addr, 32'd0);
    check("mr_r0_rdy",  32'(r0_rdy), 32'd0);
    reset = 1'b1;
    r0_en = 1'b1; r1_en = 1'b1;
    tick();
    check("mr_tie_grant", 32'(grant), 32'd0);
    check("mr_tie_addr",  m_addr, 32'h500);
    serve(1'b0, 32'h5555_5555, 32'h5555_5555);
    tick();
    check("mr_tie_b_grant", 32'(grant), 32'd1);
    serve(1'b1, 32'h6666_6666, 32'h6666_6666);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
